pb_debounce: RTL and testbench
==============================

Name: pb_debounce

Overview:
- Front-end conditioning stage between the raw left/right player pushbuttons and the game core's button inputs (pbl, pbr).
- Each channel is synchronised into the clk domain and debounced by a per-channel counter/FSM.
- Outputs per channel: a clean level, plus a one-cycle press strobe for the push-button latch logic.
- Both channels are identical and fully independent.

Parameters:
- STABLE_CYCLES, 16'd50000, consecutive clk cycles the synchronised input must hold a new value before the debounced level changes. Legal range 2..2^CNT_W-1.
- CNT_W, 16, width of each channel's stability counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- pbl_in  input  1  raw left pushbutton, asynchronous, active-high when pressed.
- pbr_in  input  1  raw right pushbutton, asynchronous, active-high when pressed.
- pbl  output  1  debounced left level.
- pbr  output  1  debounced right level.
- pbl_press  output  1  one-cycle strobe on debounced left 0->1.
- pbr_press  output  1  one-cycle strobe on debounced right 0->1.

Behaviour:
- Reset (async assert, sync release): sync flops, counters, FSM state and all outputs go to 0; state = LOW.
- Synchroniser: two flops per channel; s = second flop. All decisions use s only.
- FSM per channel, four states:
  - LOW: out=0. If s=1, go to RISE and set cnt=1.
  - RISE: out=0.
    - If s=0, go to LOW and set cnt=0 (bounce, restart).
    - Else if cnt==STABLE_CYCLES-1, go to HIGH, set out=1, press=1 for that cycle, cnt=0.
    - Else cnt+1.
  - HIGH: out=1. If s=0, go to FALL and set cnt=1.
  - FALL: out=1.
    - If s=1, go to HIGH and set cnt=0.
    - Else if cnt==STABLE_CYCLES-1, go to LOW, set out=0, cnt=0. No strobe on release.
- Latency: raw edge to output edge is exactly 2 + STABLE_CYCLES clk cycles for a clean edge.
- Outputs are registered; press is asserted in the same cycle out first reads 1.
- Any glitch shorter than STABLE_CYCLES cycles (post-synchroniser) produces no output change and no strobe.
- Counter never wraps; it saturates logically because the state always exits at STABLE_CYCLES-1.
- Simultaneous left and right presses are handled independently; both strobes may fire in the same cycle.
- Reset mid-count: the pending transition is discarded. A button held through reset release produces a press strobe 2+STABLE_CYCLES cycles after release.
- press is never high for two consecutive cycles. Between two strobes on one channel, out must have returned to 0.

Optional Feature:
- Macro: PB_PRESS_COUNT_EN.
- When defined:
  - Adds output ports pbl_count and pbr_count, 8 bits each, reset to 0.
  - Each counter increments in the cycle after its press strobe and wraps 255->0.
  - The counters are debug aids for the board's switch-selectable score display.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan (STABLE_CYCLES=4, CNT_W=4):
- Reset: hold rst=1 with pbl_in=pbr_in=1 -> all outputs 0. Release rst -> pbl and pbr rise exactly 6 cycles later, with a single-cycle strobe on each.
- Clean press: pbl_in 0->1 held 20 cycles -> pbl=1 at cycle +6, pbl_press high for exactly 1 cycle, pbr untouched.
- Bounce: pbl_in toggles 1,0,1,0 per 2 cycles, then holds 1 -> no strobe during the bounce. One strobe 6 cycles after the final rise.
- Release glitch: pbl=1, then pbl_in drops for 3 cycles and returns -> pbl stays 1 and no strobe. A subsequent 4+ cycle drop -> pbl=0 after 6 cycles, no strobe.
- Simultaneous: pbl_in and pbr_in rise in the same cycle -> pbl_press and pbr_press are asserted in the same cycle.
- Async reset mid-RISE: assert rst 2 cycles into RISE -> outputs are 0 immediately, without waiting for a clk edge. With PB_PRESS_COUNT_EN, 3 full presses -> count=3, and 256 presses -> wraps to 0.

Source files
------------

// File: rtl/pb_debounce.sv
// Two-channel pushbutton conditioner: 2-flop synchroniser plus a stability-counter FSM per channel.
// Define PB_PRESS_COUNT_EN to add 8-bit per-channel press counters (pbl_count / pbr_count).
module pb_debounce #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl_in,
  input  logic       pbr_in,
  output logic       pbl,
  output logic       pbr,
  output logic       pbl_press,
  output logic       pbr_press
`ifdef PB_PRESS_COUNT_EN
  ,
  output logic [7:0] pbl_count,
  output logic [7:0] pbr_count
`endif
);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE,
    ST_HIGH,
    ST_FALL
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [1:0] raw_in;
  logic [1:0] level_q;
  logic [1:0] press_q;
`ifdef PB_PRESS_COUNT_EN
  logic [7:0] count_q [2];
`endif

  assign raw_in = {pbr_in, pbl_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [1:0]       sync_q;
      state_t           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             out_q;
      logic             strobe_q;

      // sync_q[1] is the only copy of the button the FSM is allowed to look at.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q   <= 2'b00;
          state_q  <= ST_LOW;
          cnt_q    <= '0;
          out_q    <= 1'b0;
          strobe_q <= 1'b0;
        end else begin
          sync_q   <= {sync_q[0], raw_in[gi]};
          strobe_q <= 1'b0;
          case (state_q)
            ST_LOW: begin
              if (sync_q[1]) begin
                state_q <= ST_RISE;
                cnt_q   <= ONE_CNT;
              end
            end
            ST_RISE: begin
              if (!sync_q[1]) begin
                state_q <= ST_LOW;
                cnt_q   <= '0;
              end else if (cnt_q == LAST_CNT) begin
                state_q  <= ST_HIGH;
                out_q    <= 1'b1;
                strobe_q <= 1'b1;
                cnt_q    <= '0;
              end else begin
                cnt_q <= cnt_q + ONE_CNT;
              end
            end
            ST_HIGH: begin
              if (!sync_q[1]) begin
                state_q <= ST_FALL;
                cnt_q   <= ONE_CNT;
              end
            end
            ST_FALL: begin
              // Release is silent: only the level drops, no strobe.
              if (sync_q[1]) begin
                state_q <= ST_HIGH;
                cnt_q   <= '0;
              end else if (cnt_q == LAST_CNT) begin
                state_q <= ST_LOW;
                out_q   <= 1'b0;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + ONE_CNT;
              end
            end
            default: begin
              state_q <= ST_LOW;
              cnt_q   <= '0;
              out_q   <= 1'b0;
            end
          endcase
        end
      end

      assign level_q[gi] = out_q;
      assign press_q[gi] = strobe_q;

`ifdef PB_PRESS_COUNT_EN
      // Counts the strobe one cycle late and wraps naturally at 8 bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q[gi] <= 8'd0;
        end else if (strobe_q) begin
          count_q[gi] <= count_q[gi] + 8'd1;
        end
      end
`endif
    end
  endgenerate

  assign pbl       = level_q[0];
  assign pbr       = level_q[1];
  assign pbl_press = press_q[0];
  assign pbr_press = press_q[1];
`ifdef PB_PRESS_COUNT_EN
  assign pbl_count = count_q[0];
  assign pbr_count = count_q[1];
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce with STABLE_CYCLES=4, CNT_W=4.
// A run-length reference model predicts every output cycle by cycle.
module tb_pb_debounce;
  localparam int STABLE = 4;
  localparam int LAT    = 2 + STABLE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pbl_in = 1'b0;
  logic pbr_in = 1'b0;
  logic pbl, pbr, pbl_press, pbr_press;
`ifdef PB_PRESS_COUNT_EN
  logic [7:0] pbl_count, pbr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pb_debounce #(.CNT_W(4), .STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .pbl_in    (pbl_in),
    .pbr_in    (pbr_in),
    .pbl       (pbl),
    .pbr       (pbr),
    .pbl_press (pbl_press),
    .pbr_press (pbr_press)
`ifdef PB_PRESS_COUNT_EN
    ,
    .pbl_count (pbl_count),
    .pbr_count (pbr_count)
`endif
  );

  // Reference: the level flips once the synchronised input has disagreed with it
  // for STABLE consecutive cycles; a rising flip also produces the strobe.
  logic [1:0] m_s1, m_s2, m_out, m_press;
  int         m_run [2];
`ifdef PB_PRESS_COUNT_EN
  logic [7:0] m_cnt [2];
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= 2'b00; m_s2 <= 2'b00; m_out <= 2'b00; m_press <= 2'b00;
      m_run[0] <= 0; m_run[1] <= 0;
`ifdef PB_PRESS_COUNT_EN
      m_cnt[0] <= 8'd0; m_cnt[1] <= 8'd0;
`endif
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_s2[c] != m_out[c]) begin
          if (m_run[c] + 1 >= STABLE) begin
            m_out[c]   <= ~m_out[c];
            m_press[c] <= ~m_out[c];
            m_run[c]   <= 0;
          end else begin
            m_run[c]   <= m_run[c] + 1;
            m_press[c] <= 1'b0;
          end
        end else begin
          m_run[c]   <= 0;
          m_press[c] <= 1'b0;
        end
`ifdef PB_PRESS_COUNT_EN
        m_cnt[c] <= m_cnt[c] + {7'd0, m_press[c]};
`endif
      end
      m_s1 <= {pbr_in, pbl_in};
      m_s2 <= m_s1;
    end
  end

  task automatic test_reset();
    int first_l = -1, first_r = -1, nl = 0, nr = 0;
    pbl_in = 1'b1; pbr_in = 1'b1; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== 4'b0000) begin
        errors++; $display("FAIL reset_hold: got %b want 0000", {pbr_press, pbl_press, pbr, pbl});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL reset_release k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      if (pbl && first_l < 0) first_l = k;
      if (pbr && first_r < 0) first_r = k;
      nl += int'(pbl_press); nr += int'(pbr_press);
    end
    checks++;
    if (first_l != LAT || first_r != LAT || nl != 1 || nr != 1) begin
      errors++; $display("FAIL reset_release_latency: got l=%0d r=%0d strobes=%0d/%0d want %0d %0d 1/1", first_l, first_r, nl, nr, LAT, LAT);
    end
  endtask

  task automatic test_clean_press();
    int first = -1, nl = 0, r_seen = 0;
    pbl_in = 1'b0; pbr_in = 1'b0;
    repeat (12) @(negedge clk);
    pbl_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL clean_press k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      if (pbl && first < 0) first = k;
      nl += int'(pbl_press);
      r_seen += int'(pbr | pbr_press);
    end
    checks++;
    if (first != LAT || nl != 1 || r_seen != 0) begin
      errors++; $display("FAIL clean_press_timing: got rise=%0d strobes=%0d pbr_activity=%0d want %0d 1 0", first, nl, r_seen, LAT);
    end
    pbl_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_bounce();
    logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int strobe_k = -1, bounce_strobes = 0, nl = 0;
    for (int k = 1; k <= 23; k++) begin
      pbl_in = (k <= 8) ? pat[k-1] : 1'b1;
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL bounce k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      if (pbl_press) begin
        nl++;
        if (strobe_k < 0) strobe_k = k;
        if (k <= 8) bounce_strobes++;
      end
    end
    checks++;
    if (bounce_strobes != 0 || nl != 1 || strobe_k != 8 + LAT) begin
      errors++; $display("FAIL bounce_strobe: got at=%0d count=%0d during_bounce=%0d want at=%0d count=1 0", strobe_k, nl, bounce_strobes, 8 + LAT);
    end
  endtask

  task automatic test_release_glitch();
    int dropped = 0, nl = 0, fall = -1;
    for (int k = 1; k <= 13; k++) begin
      pbl_in = (k <= 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL release_glitch k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      dropped += int'(!pbl);
      nl += int'(pbl_press);
    end
    checks++;
    if (dropped != 0 || nl != 0) begin
      errors++; $display("FAIL release_glitch_hold: got low_cycles=%0d strobes=%0d want 0 0", dropped, nl);
    end
    pbl_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL release k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      if (!pbl && fall < 0) fall = k;
      nl += int'(pbl_press);
    end
    checks++;
    if (fall != LAT || nl != 0) begin
      errors++; $display("FAIL release_timing: got fall=%0d strobes=%0d want %0d 0", fall, nl, LAT);
    end
  endtask

  task automatic test_simultaneous();
    int kl = -1, kr = -1;
    pbl_in = 1'b0; pbr_in = 1'b0;
    repeat (12) @(negedge clk);
    pbl_in = 1'b1; pbr_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL simultaneous k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      if (pbl_press) kl = k;
      if (pbr_press) kr = k;
    end
    checks++;
    if (kl != LAT || kr != LAT) begin
      errors++; $display("FAIL simultaneous_strobe: got l=%0d r=%0d want %0d %0d", kl, kr, LAT, LAT);
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    // Both buttons are held high here: levels are 1 going in.
    @(posedge clk); #2; rst = 1'b1; #1;
    checks++;
    if ({pbr_press, pbl_press, pbr, pbl} !== 4'b0000) begin
      errors++; $display("FAIL async_reset_high: got %b want 0000", {pbr_press, pbl_press, pbr, pbl});
    end
    @(negedge clk); rst = 1'b0; pbl_in = 1'b0; pbr_in = 1'b0;
    repeat (8) @(negedge clk);
    pbl_in = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #2; rst = 1'b1; #1;
    checks++;
    if ({pbr_press, pbl_press, pbr, pbl} !== 4'b0000) begin
      errors++; $display("FAIL async_reset_rise: got %b want 0000", {pbr_press, pbl_press, pbr, pbl});
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out}) begin
        errors++; $display("FAIL post_reset k=%0d: got %b want %b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out});
      end
      if (pbl_press && first < 0) first = k;
    end
    checks++;
    if (first != LAT) begin
      errors++; $display("FAIL post_reset_strobe: got %0d want %0d", first, LAT);
    end
  endtask

  task automatic test_random();
    logic [1:0] prev = 2'b00;
    for (int k = 0; k < 800; k++) begin
      int odds = (k < 400) ? 3 : 9;
      if ($urandom_range(0, odds - 1) == 0) pbl_in = ~pbl_in;
      if ($urandom_range(0, odds - 1) == 0) pbr_in = ~pbr_in;
      @(negedge clk);
      checks++;
      if ({pbr_press, pbl_press, pbr, pbl} !== {m_press, m_out} || (prev & {pbr_press, pbl_press}) != 2'b00) begin
        errors++; $display("FAIL random k=%0d: got %b want %b prev_press=%b", k, {pbr_press, pbl_press, pbr, pbl}, {m_press, m_out}, prev);
      end
      prev = {pbr_press, pbl_press};
    end
  endtask

`ifdef PB_PRESS_COUNT_EN
  task automatic test_count();
    @(negedge clk); rst = 1'b1; pbl_in = 1'b0; pbr_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int p = 1; p <= 256; p++) begin
      pbl_in = 1'b1; pbr_in = 1'b1;
      repeat (9) @(negedge clk);
      pbl_in = 1'b0; pbr_in = 1'b0;
      repeat (9) @(negedge clk);
      if (p == 3 || p == 256) begin
        checks++;
        if (pbl_count !== 8'(p) || pbr_count !== 8'(p) || pbl_count !== m_cnt[0]) begin
          errors++; $display("FAIL count_%0d: got l=%0d r=%0d want %0d", p, pbl_count, pbr_count, 8'(p));
        end
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_async_reset();
    test_random();
`ifdef PB_PRESS_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
